// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous RAM port.
// Each access walks IDLE -> ISSUE -> DONE. Every output is registered
// except the read-data returns, which pass the RAM output straight through
// while the owner's ack is high.
module mem_arbiter #(
   parameter int         AW     = 9,
   parameter int         DW     = 16,
   parameter logic [1:0] MNONE  = 2'b00,
   parameter logic [1:0] MREAD  = 2'b01,
   parameter logic [1:0] MWRITE = 2'b10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    cmd0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic [1:0]    cmd1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          prio_q, prio_d;
   logic          rd_q, rd_d;
   logic [1:0]    mem_cmd_q, mem_cmd_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          busy_q, busy_d;

   logic          req0, req1, win1;
   logic [1:0]    sel_cmd;

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         prio_q      <= 1'b0;
         rd_q        <= 1'b0;
         mem_cmd_q   <= MNONE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         prio_q      <= prio_d;
         rd_q        <= rd_d;
         mem_cmd_q   <= mem_cmd_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         busy_q      <= busy_d;
      end
   end

   // Arbitration, next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      prio_d      = prio_q;
      rd_d        = rd_q;
      mem_cmd_d   = mem_cmd_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      busy_d      = busy_q;

      // 2'b11 is not a request; only MREAD/MWRITE compete.
      req0    = (cmd0 == MREAD) || (cmd0 == MWRITE);
      req1    = (cmd1 == MREAD) || (cmd1 == MWRITE);
      win1    = req1 && (!req0 || prio_q);
      sel_cmd = win1 ? cmd1 : cmd0;

      case (state_q)
         S_IDLE: begin
            mem_cmd_d = MNONE;
            if (req0 || req1) begin
               state_d     = S_ISSUE;
               owner_d     = win1;
               rd_d        = (sel_cmd == MREAD);
               mem_cmd_d   = sel_cmd;
               mem_addr_d  = win1 ? addr1 : addr0;
               mem_wdata_d = win1 ? wdata1 : wdata0;
               busy_d      = 1'b1;
            end
         end
         S_ISSUE: begin
            // RAM samples the command on this closing edge.
            state_d   = S_DONE;
            mem_cmd_d = MNONE;
            ack0_d    = !owner_q;
            ack1_d    = owner_q;
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            prio_d  = !owner_q;
         end
         default: begin
            state_d   = S_IDLE;
            mem_cmd_d = MNONE;
            busy_d    = 1'b0;
         end
      endcase
   end

   assign mem_cmd   = mem_cmd_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign busy      = busy_q;
   assign owner     = owner_q;

   // Registered RAM data arrives in DONE, exactly when the ack is high.
   assign rdata0 = (ack0_q && rd_q) ? mem_rdata : '0;
   assign rdata1 = (ack1_q && rd_q) ? mem_rdata : '0;

endmodule
